// File: rtl/comb_truth_tbl_sweep.sv
// comb_truth_tbl_sweep: drives all 16 minterms into a downstream
// truth-table block, captures f per minterm, hands the word out on val/rdy.
module comb_truth_tbl_sweep #(
   parameter int unsigned LAT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   input  logic        f,
   output logic        tbl_val,
   input  logic        tbl_rdy,
   output logic [15:0] tbl
);

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } state_t;

   // Last dwell count of a minterm: f has crossed LAT stages by then.
   localparam logic [2:0] HOLD_LAST = 3'(LAT);

   state_t      state_q;
   logic [3:0]  idx_q;
   logic [2:0]  hold_q;
   logic [15:0] tbl_q;
   logic [3:0]  drv_q;
   logic        busy_q;
   logic        val_q;

   logic        sample_d;
   logic        last_d;

   // Sampling strobe: the only cycle in which f is allowed into tbl.
   always_comb begin
      sample_d = (state_q == SWEEP) && (hold_q == HOLD_LAST);
      last_d   = (idx_q == 4'hF);
   end

   // Sweep FSM with registered minterm drive, busy and valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
         tbl_q   <= '0;
         drv_q   <= '0;
         busy_q  <= 1'b0;
         val_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= SWEEP;
                  idx_q   <= '0;
                  hold_q  <= '0;
                  tbl_q   <= '0;
                  drv_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            SWEEP: begin
               if (sample_d) begin
                  tbl_q[idx_q] <= f;
                  if (last_d) begin
                     state_q <= DONE;
                     drv_q   <= '0;
                     val_q   <= 1'b1;
                  end else begin
                     idx_q  <= idx_q + 4'd1;
                     hold_q <= '0;
                     drv_q  <= idx_q + 4'd1;
                  end
               end else begin
                  hold_q <= hold_q + 3'd1;
               end
            end
            DONE: begin
               if (tbl_rdy) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  val_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               val_q   <= 1'b0;
               drv_q   <= '0;
            end
         endcase
      end
   end

   assign {a, b, c, d} = drv_q;
   assign busy         = busy_q;
   assign tbl_val      = val_q;
   assign tbl          = tbl_q;

endmodule

// File: doc/comb_truth_tbl_sweep.md
# comb_truth_tbl_sweep

Sequential stimulus-and-capture stage that sits directly upstream of a 4-input combinational truth-table block.
- On a start pulse it walks the four inputs {a,b,c,d} through all 16 minterms, samples the block's f output once per minterm, and packs the results into a 16-bit truth-table word.
- The word is delivered on a val/rdy output interface.
- Used to characterise or self-check combinational truth-table stages in place.

## Interface
- LAT, default 0: register stages between this block's {a,b,c,d} outputs and the f it receives. Legal range 0..7.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- busy  output  1  high in SWEEP and DONE.
- a, b, c, d  output  1 each  minterm drive; {a,b,c,d} = current index, with a as MSB.
- f  input  1  response of the downstream truth-table block.
- tbl_val  output  1  truth-table word valid.
- tbl_rdy  input  1  consumer ready for the truth-table word.
- tbl  output  16  captured table; tbl[i] = f observed for {a,b,c,d} = i.

## Operation
- FSM states are IDLE, SWEEP and DONE. Reset state is IDLE.
- Internal state:
  - idx: 4-bit minterm index.
  - hold: 3-bit dwell counter.
  - tbl: 16-bit shadow register.
- IDLE:
  - {a,b,c,d} = 0, busy = 0, tbl_val = 0. tbl holds the last captured value.
  - start = 1 moves to SWEEP with idx = 0, hold = 0, and tbl cleared to 0.
- SWEEP:
  - {a,b,c,d} = idx; busy = 1.
  - Each minterm is held for LAT+1 cycles; hold counts 0..LAT.
  - In the cycle where hold == LAT, f is written into tbl[idx].
  - If idx != 15 in that cycle: idx increments and hold resets to 0.
  - If idx == 15 in that cycle: transition to DONE.
  - idx never wraps inside a sweep.
- DONE:
  - {a,b,c,d} = 0, busy = 1, tbl_val = 1, tbl stable.
  - tbl_val && tbl_rdy completes the transfer: next state IDLE, tbl retained.
  - tbl_val stays high and tbl stays unchanged until the transfer completes.
- start is ignored in SWEEP and DONE.
  - start and a completed transfer in the same DONE cycle: transfer wins, go to IDLE, no new sweep begins.
  - start in the first IDLE cycle after DONE is honoured.
- f is ignored except in sampling cycles. Unknown or X values on f in non-sampling cycles must not corrupt tbl.
- Reset, asynchronous at any point including mid-sweep:
  - State returns immediately to IDLE.
  - idx = 0, hold = 0, tbl = 0.
  - All outputs go to 0: a, b, c, d, busy, tbl_val, tbl.
  - A partial sweep is discarded; nothing is reported.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- Minterm k is driven from cycle 1 + k·(LAT+1) through cycle (k+1)·(LAT+1).
- f for minterm k is sampled at the end of cycle (k+1)·(LAT+1).
- tbl_val first asserts in cycle 16·(LAT+1) + 1, i.e. cycle 17 when LAT = 0.
- Minimum start-to-start interval is 16·(LAT+1) + 2 cycles, with tbl_rdy held high.
- Outputs a, b, c, d, busy, tbl_val and tbl are registered, or decoded only from registered state; none depends combinationally on start, f or tbl_rdy.
- No combinational path exists from f to any output.

## Test plan
- Reset mid-sweep: assert reset at cycle 5 of a sweep.
  - Required: all outputs 0 in the same cycle, state IDLE.
  - A following start performs a full clean sweep.
- Nominal, LAT = 0, downstream f = 1 for minterms {0,1,4,5,8,10,13,15}, tbl_rdy = 1.
  - Required: {a,b,c,d} = 0..15 on cycles 1..16.
  - Required: tbl_val = 1 at cycle 17 with tbl = 16'hA533; busy drops at cycle 18.
- Backpressure: same stimulus with tbl_rdy = 0 for 10 cycles after tbl_val rises, then 1.
  - Required: tbl_val held high and tbl = 16'hA533 stable throughout; one transfer only.
- LAT = 2 with a two-flop delayed f model (same function).
  - Required: each minterm held 3 cycles; tbl = 16'hA533; tbl_val at cycle 49.
- Start handling:
  - start pulses during SWEEP and DONE are ignored.
  - start coincident with the DONE transfer yields IDLE with no new sweep.
  - start on the next IDLE cycle begins a sweep with tbl cleared.
- Constant responses: f tied to 0, then f tied to 1.
  - Required: tbl = 16'h0000, then 16'hFFFF.
  - X on f outside sampling cycles leaves tbl unaffected.
